fft_peak_detect: RTL
====================

FFT_PEAK_DETECT -- requirements
Module: fft_peak_detect

Interface
REQ-001 Parameter: MIN_MAG, default 17'd0, minimum magnitude a bin needs to be reported as a peak.
REQ-002 clk  input  1  system clock; all logic is rising-edge.
REQ-003 rst  input  1  reset; synchronous and active-low.
REQ-004 in_valid  input  1  one bin beat is present this cycle.
REQ-005 in_re  input  16  bin real part, signed two's complement.
REQ-006 in_im  input  16  bin imaginary part, signed two's complement.
REQ-007 in_index  input  3  bin number 0..7 of the current beat.
REQ-008 peak_valid  output  1  one-cycle pulse: frame result is valid.
REQ-009 peak_found  output  1  at least one eligible bin had mag > MIN_MAG; qualified by peak_valid.
REQ-010 peak_index  output  3  bin number of the largest magnitude.
REQ-011 peak_mag  output  17  approximate magnitude of that bin, unsigned.
REQ-012 frame_err  output  1  one-cycle pulse: a frame was aborted by a sequencing error.
REQ-013 busy  output  1  high while a frame is partially received (state SCAN).

Function
REQ-014 The magnitude SHALL be mag = |in_re| + |in_im|, computed at 17 bits unsigned; |-32768| = 32768, with no saturation.
REQ-015 The block SHALL be a 2-stage pipeline.
- Stage 1 registers the abs values, index and valid.
- Stage 2 forms the sum and runs the compare/track logic.
REQ-016 The FSM SHALL have the states IDLE, SCAN and DONE; it leaves reset in IDLE.
REQ-017 IDLE: a stage-2 beat with index 0 SHALL load the tracker (best_idx = 0, best_mag = mag) and move to SCAN; any other index is dropped silently.
REQ-018 SCAN: a beat whose index is expected_idx (last index + 1) SHALL update the tracker only if mag > best_mag (strict, so on ties the lowest index wins).
REQ-019 SCAN: a beat with index 7 that is accepted SHALL move the FSM to DONE.
REQ-020 SCAN: a beat with index 0 SHALL pulse frame_err, discard the partial frame and restart the tracker with that beat (remain in SCAN).
REQ-021 SCAN: a beat with any other out-of-order index SHALL pulse frame_err and return to IDLE.
REQ-022 Gaps (in_valid low) inside a frame SHALL be allowed, with no timeout.
REQ-023 DONE SHALL last exactly one cycle.
- It pulses peak_valid and loads peak_index and peak_mag.
- peak_found = (best_mag > MIN_MAG).
- It then returns to IDLE.
- A beat arriving in the DONE cycle SHALL be processed as if it arrived in IDLE.
REQ-024 Latency: peak_valid SHALL rise 3 cycles after the clk edge that samples in_valid with in_index 7.
REQ-025 Back-to-back frames at 1 beat/cycle SHALL be supported without loss.
REQ-026 peak_index, peak_mag and peak_found SHALL hold their values until the next DONE.
REQ-027 busy SHALL equal (state == SCAN).

Reset
REQ-028 While rst = 0 at a clk edge, the block SHALL do the following:
- state goes to IDLE.
- Pipeline valids clear.
- The tracker clears.
- peak_valid, peak_found, frame_err and busy are 0.
- peak_index = 0 and peak_mag = 0.
REQ-029 A reset mid-frame SHALL discard the frame without pulsing frame_err; the first beat after reset release SHALL be processed normally.

Configuration
REQ-030 Macro PEAK_SKIP_DC_EN.
- When defined, bin 0 SHALL be ineligible: the index-0 beat starts the frame but loads best_mag = 0 and best_idx = 1, and the compare runs over bins 1..7 only.
- When undefined, all 8 bins are eligible as described above.
- Latency and sequencing rules are identical in both builds.

Verification
REQ-031 Frame with bin 3 = (re 100, im -50) and all others (10, 10) -> 3 cycles after index 7: peak_valid = 1, peak_index = 3, peak_mag = 150, peak_found = 1.
REQ-032 Bin 0 = (1000, 0), others (5, 5):
- Without PEAK_SKIP_DC_EN -> peak_index = 0, peak_mag = 1000.
- With it -> peak_index = 1, peak_mag = 10.
REQ-033 Bins 2 and 5 both at mag 200 (highest) -> peak_index = 2 (tie goes to the lower index).
REQ-034 Indices 0, 1, 2, 4 -> frame_err pulse on the beat carrying index 4, busy falls, no peak_valid.
- Next clean frame 0..7 -> normal result.
REQ-035 Bin 6 = (-32768, -32768), MIN_MAG = 70000 -> peak_mag = 65536, peak_index = 6, peak_found = 0.
REQ-036 Two frames back-to-back at 1 beat/cycle -> two peak_valid pulses 8 cycles apart.
- rst low at the beat with index 4 of a third frame -> no peak_valid and no frame_err, and all outputs are 0 after reset.

Source files
------------

// File: rtl/fft_peak_detect.sv
// ---------------------------------------------------------------------------
// fft_peak_detect
//
// Scans one 8-bin FFT frame (bins arrive as beats tagged with their index
// 0..7, gaps allowed) and reports the bin with the largest approximate
// magnitude |re| + |im|. Beats go through a short pipeline: stage 1
// registers the absolute values, stage 2 registers their sum, and the
// tracker FSM (IDLE -> SCAN -> DONE) consumes the stage-2 beat. The result
// is published on the registered outputs during the one-cycle DONE state.
//
// Build option: define PEAK_SKIP_DC_EN to exclude bin 0 from the peak
// search (frame sequencing is unchanged). Default build: all bins eligible.
//
// Parameters
//   MIN_MAG     minimum magnitude (exclusive) for peak_found
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-low reset
//   in_valid    bin beat present this cycle
//   in_re/in_im bin real / imaginary part, signed 16 bit
//   in_index    bin number 0..7 of the beat
//   peak_valid  one-cycle pulse, frame result valid
//   peak_found  best magnitude exceeded MIN_MAG
//   peak_index  bin number of the largest magnitude
//   peak_mag    that magnitude, unsigned 17 bit
//   frame_err   one-cycle pulse, frame aborted by a sequencing error
//   busy        a frame is partially received (state SCAN)
//
// Handshake: no back-pressure. A beat is consumed on every rising clk edge
// where in_valid is high; outputs are registered and valid only in the
// cycle peak_valid is high (peak_* data then holds until the next result).
// ---------------------------------------------------------------------------
module fft_peak_detect #(
    parameter logic [16:0] MIN_MAG = 17'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] in_re,
    input  logic [15:0] in_im,
    input  logic [2:0]  in_index,
    output logic        peak_valid,
    output logic        peak_found,
    output logic [2:0]  peak_index,
    output logic [16:0] peak_mag,
    output logic        frame_err,
    output logic        busy
);

`ifdef PEAK_SKIP_DC_EN
    localparam logic SKIP_DC = 1'b1;
`else
    localparam logic SKIP_DC = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Sign-extend to 17 bits before negating so |-32768| = 32768 exactly.
    function automatic logic [16:0] abs17(input logic [15:0] v);
        logic [16:0] ext;
        ext = {v[15], v};
        return v[15] ? (~ext + 17'd1) : ext;
    endfunction

    // Stage 1: absolute values
    logic        s1_valid_q;
    logic [16:0] s1_re_q, s1_im_q;
    logic [2:0]  s1_idx_q;
    logic [16:0] re_abs_d, im_abs_d;

    // Stage 2: magnitude
    logic        s2_valid_q;
    logic [16:0] s2_mag_q;
    logic [2:0]  s2_idx_q;
    logic [16:0] mag_d;

    // Tracker / FSM
    state_t      state_q;
    logic [2:0]  last_idx_q;
    logic [2:0]  best_idx_q;
    logic [16:0] best_mag_q;
    logic [2:0]  exp_idx_d;

    logic        peak_valid_q, peak_found_q, frame_err_q;
    logic [2:0]  peak_index_q;
    logic [16:0] peak_mag_q;

    assign re_abs_d  = abs17(in_re);
    assign im_abs_d  = abs17(in_im);
    // Both operands are at most 32768, so the sum fits in 17 bits.
    assign mag_d     = s1_re_q + s1_im_q;
    assign exp_idx_d = last_idx_q + 3'd1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_re_q    <= '0;
            s1_im_q    <= '0;
            s1_idx_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_mag_q   <= '0;
            s2_idx_q   <= '0;
        end else begin
            s1_valid_q <= in_valid;
            s1_re_q    <= re_abs_d;
            s1_im_q    <= im_abs_d;
            s1_idx_q   <= in_index;
            s2_valid_q <= s1_valid_q;
            s2_mag_q   <= mag_d;
            s2_idx_q   <= s1_idx_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_idx_q   <= '0;
            best_idx_q   <= '0;
            best_mag_q   <= '0;
            peak_valid_q <= 1'b0;
            peak_found_q <= 1'b0;
            peak_index_q <= '0;
            peak_mag_q   <= '0;
            frame_err_q  <= 1'b0;
        end else begin
            peak_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (state_q == DONE) begin
                        peak_valid_q <= 1'b1;
                        peak_index_q <= best_idx_q;
                        peak_mag_q   <= best_mag_q;
                        peak_found_q <= (best_mag_q > MIN_MAG);
                    end
                    state_q <= IDLE;
                    // A beat in the DONE cycle is handled exactly as in IDLE.
                    if (s2_valid_q && s2_idx_q == 3'd0) begin
                        last_idx_q <= 3'd0;
                        best_idx_q <= SKIP_DC ? 3'd1 : 3'd0;
                        best_mag_q <= SKIP_DC ? 17'd0 : s2_mag_q;
                        state_q    <= SCAN;
                    end
                end
                SCAN: begin
                    if (s2_valid_q) begin
                        if (s2_idx_q == exp_idx_d) begin
                            // Strict compare: ties keep the lower index.
                            if (s2_mag_q > best_mag_q) begin
                                best_mag_q <= s2_mag_q;
                                best_idx_q <= s2_idx_q;
                            end
                            last_idx_q <= s2_idx_q;
                            if (s2_idx_q == 3'd7) begin
                                state_q <= DONE;
                            end
                        end else if (s2_idx_q == 3'd0) begin
                            // Restart on a fresh index 0; stay in SCAN.
                            frame_err_q <= 1'b1;
                            last_idx_q  <= 3'd0;
                            best_idx_q  <= SKIP_DC ? 3'd1 : 3'd0;
                            best_mag_q  <= SKIP_DC ? 17'd0 : s2_mag_q;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign peak_valid = peak_valid_q;
    assign peak_found = peak_found_q;
    assign peak_index = peak_index_q;
    assign peak_mag   = peak_mag_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q == SCAN);

endmodule
